fb_write_arbiter: RTL and testbench

- Owns the single frame-buffer write port that feeds the red, green, blue and special buffers.
- Shares that port between two writers: the Painter's pixel writes, and a built-in clear engine that fills the whole buffer with one colour.
- The clear engine yields the port to the Painter at fixed burst boundaries, so drawing never stalls for a full clear.
- Sits between Painter and the frame-buffer BlockRams, replacing Painter's direct addr/data/we connection.

---
 rtl/fb_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: shares one write port between Painter pixel writes and a full-buffer clear engine.
// Latency: the write that wins arbitration in cycle N appears on fb_we/fb_addr/fb_data in cycle N+1.
// Backpressure: p_grant withholds the Painter for at most BURST cycles while a clear runs.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   p_req/p_addr/p_color  Painter pixel write request; p_grant accepts it in the same cycle
//   clr_start/clr_color   start a fill of addresses 0..FB_SIZE-1 with clr_color
//   clr_busy/clr_done     clear in progress / one-cycle pulse aligned with the last clear write
//   fb_we/fb_addr/fb_data registered frame-buffer write port
module fb_write_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int FB_SIZE = 36864,   // must not exceed 2**ADDR_W
    parameter int BURST   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [2:0]        p_color,
    output logic              p_grant,
    input  logic              clr_start,
    input  logic [2:0]        clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data
);

    localparam int                BC_W     = $clog2(BURST + 1);
    localparam logic [BC_W-1:0]   BURST_C  = BC_W'(BURST);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FB_SIZE - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [2:0]        color_q, color_d;
    logic              clr_done_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [2:0]        fb_data_q;

    // Write selected this cycle; iss_addr/iss_data default to the held values
    // so the registered port keeps its contents on idle cycles.
    logic              iss_vld;
    logic [ADDR_W-1:0] iss_addr;
    logic [2:0]        iss_data;
    logic              last_clr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clr_ptr_q   <= '0;
            burst_cnt_q <= '0;
            color_q     <= '0;
            clr_done_q  <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            color_q     <= color_d;
            clr_done_q  <= last_clr;
            fb_we_q     <= iss_vld;
            fb_addr_q   <= iss_addr;
            fb_data_q   <= iss_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        color_d     = color_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    color_d     = clr_color;
                    clr_ptr_d   = '0;
                    burst_cnt_d = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (p_grant) begin
                    burst_cnt_d = '0;
                end else begin
                    // Saturate so a late Painter request is served on its first cycle.
                    if (burst_cnt_q != BURST_C) begin
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                    end
                    if (last_clr) begin
                        state_d = S_IDLE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / arbitration logic
    always_comb begin
        p_grant  = 1'b0;
        iss_vld  = 1'b0;
        iss_addr = fb_addr_q;
        iss_data = fb_data_q;
        last_clr = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (p_req) begin
                        p_grant  = 1'b1;
                        iss_vld  = 1'b1;
                        iss_addr = p_addr;
                        iss_data = p_color;
                    end
                end
                S_CLEAR: begin
                    if (p_req && (burst_cnt_q == BURST_C)) begin
                        p_grant  = 1'b1;
                        iss_vld  = 1'b1;
                        iss_addr = p_addr;
                        iss_data = p_color;
                    end else begin
                        iss_vld  = 1'b1;
                        iss_addr = clr_ptr_q;
                        iss_data = color_q;
                        last_clr = (clr_ptr_q == LAST_PTR);
                    end
                end
                default: ;
            endcase
        end
    end

    assign clr_busy = (state_q == S_CLEAR);
    assign clr_done = clr_done_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

    localparam int ADDR_W  = 16;
    localparam int FB_SIZE = 40;
    localparam int BURST   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              p_req;
    logic [ADDR_W-1:0] p_addr;
    logic [2:0]        p_color;
    logic              p_grant;
    logic              clr_start;
    logic [2:0]        clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;

    int n_cmp  = 0;
    int n_fail = 0;

    fb_write_arbiter #(
        .ADDR_W (ADDR_W),
        .FB_SIZE(FB_SIZE),
        .BURST  (BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_req    (p_req),
        .p_addr   (p_addr),
        .p_color  (p_color),
        .p_grant  (p_grant),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear with no Painter traffic; optionally pulse clr_start (colour 111)
    // just before clear address inj is issued.
    task automatic clear_run(input logic [2:0] col, input int inj);
        clr_start = 1'b1;
        clr_color = col;
        step();
        clr_start = 1'b0;
        clr_color = 3'b000;
        for (int k = 0; k < FB_SIZE; k++) begin
            chk("busy_during_clear", clr_busy, 1'b1);
            if (k == inj) begin
                clr_start = 1'b1;
                clr_color = 3'b111;
            end
            step();
            clr_start = 1'b0;
            chk("clr_we", fb_we, 1'b1);
            chk("clr_addr", fb_addr, k);
            chk("clr_data", fb_data, col);
            chk("clr_done_pos", clr_done, (k == FB_SIZE - 1));
        end
        chk("busy_after_clear", clr_busy, 1'b0);
        step();
        chk("done_single_pulse", clr_done, 1'b0);
        chk("we_idle_after_clear", fb_we, 1'b0);
        chk("busy_stays_low", clr_busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        p_req     = 1'b1;
        p_addr    = 16'h00AA;
        p_color   = 3'b111;
        clr_start = 1'b0;
        clr_color = 3'b000;
        step();
        step();
        // Reset state, with a Painter request held during reset.
        chk("rst_grant", p_grant, 1'b0);
        chk("rst_we", fb_we, 1'b0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        reset = 1'b0;
        p_req = 1'b0;
        step();
        chk("idle_we", fb_we, 1'b0);

        // Idle Painter writes at 5, 6, 7 with colour 101.
        for (int i = 0; i < 3; i++) begin
            p_req   = 1'b1;
            p_addr  = 16'(5 + i);
            p_color = 3'b101;
            #1;
            chk("idle_grant", p_grant, 1'b1);
            step();
            chk("idle_p_we", fb_we, 1'b1);
            chk("idle_p_addr", fb_addr, 5 + i);
            chk("idle_p_data", fb_data, 3'b101);
        end
        p_req = 1'b0;
        #1;
        chk("idle_no_grant", p_grant, 1'b0);
        step();
        chk("hold_we", fb_we, 1'b0);
        chk("hold_addr", fb_addr, 7);
        chk("hold_data", fb_data, 3'b101);

        // Clear without contention, colour 010.
        clear_run(3'b010, -1);

        // Clear with an ignored clr_start (colour 111) while busy.
        clear_run(3'b110, 10);

        // Simultaneous start plus contention for the whole clear.
        p_req     = 1'b1;
        p_addr    = 16'h0100;
        p_color   = 3'b110;
        clr_start = 1'b1;
        clr_color = 3'b001;
        #1;
        chk("sim_grant", p_grant, 1'b1);
        step();
        clr_start = 1'b0;
        chk("sim_p_we", fb_we, 1'b1);
        chk("sim_p_addr", fb_addr, 16'h0100);
        chk("sim_p_data", fb_data, 3'b110);
        chk("sim_busy", clr_busy, 1'b1);
        for (int b = 0; b < FB_SIZE / BURST; b++) begin
            for (int j = 0; j < BURST; j++) begin
                chk("cont_no_grant", p_grant, 1'b0);
                step();
                chk("cont_c_we", fb_we, 1'b1);
                chk("cont_c_addr", fb_addr, b * BURST + j);
                chk("cont_c_data", fb_data, 3'b001);
                chk("cont_done", clr_done, (b == FB_SIZE / BURST - 1) && (j == BURST - 1));
            end
            if (b < FB_SIZE / BURST - 1) begin
                chk("cont_grant", p_grant, 1'b1);
                step();
                chk("cont_p_we", fb_we, 1'b1);
                chk("cont_p_addr", fb_addr, 16'h0100);
                chk("cont_p_data", fb_data, 3'b110);
                chk("cont_p_nodone", clr_done, 1'b0);
            end
        end
        chk("cont_busy_end", clr_busy, 1'b0);
        p_req = 1'b0;
        step();
        chk("cont_we_end", fb_we, 1'b0);
        chk("cont_done_end", clr_done, 1'b0);

        // Reset while clear address 20 is being issued.
        clr_start = 1'b1;
        clr_color = 3'b011;
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
        end
        chk("pre_rst_addr", fb_addr, 19);
        chk("pre_rst_data", fb_data, 3'b011);
        reset = 1'b1;
        step();
        chk("mid_rst_we", fb_we, 1'b0);
        chk("mid_rst_busy", clr_busy, 1'b0);
        chk("mid_rst_done", clr_done, 1'b0);
        chk("mid_rst_addr", fb_addr, 0);
        reset = 1'b0;
        step();
        chk("post_rst_we", fb_we, 1'b0);
        chk("post_rst_busy", clr_busy, 1'b0);
        chk("post_rst_done", clr_done, 1'b0);

        // Fresh clear restarts from address 0.
        clear_run(3'b100, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
